fir_coef_sequencer: RTL and testbench

//  Consumer and master of the 25-bit coefficient table. Drives sel_cte and reads cte back.
//  On each accepted input sample it shifts a tap delay line, then steps sel_cte through

---
 rtl/fir_coef_sequencer_pkg.sv | 17 +
 rtl/fir_coef_sequencer_mac_sat_unit.sv | 65 ++++++
 rtl/fir_coef_sequencer.sv | 116 +++++++++++
 tb/tb_fir_coef_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/fir_coef_sequencer_pkg.sv
// Shared types and defaults for the FIR coefficient sequencer.
// Build option COEF_SAT_EN (see the MAC unit) selects saturating vs wrapping output.
package fir_coef_sequencer_pkg;

    localparam int unsigned CANT_BITS_DEF = 25;
    localparam int unsigned FRAC_BITS_DEF = 14;
    localparam int unsigned MAX_TAPS      = 8;
    // Guard bits above the full product so up to MAX_TAPS terms never overflow.
    localparam int unsigned ACC_GUARD     = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_e;

endpackage

// File: rtl/fir_coef_sequencer_mac_sat_unit.sv
// Signed multiply-accumulate with fixed-point shift and output range handling.
// COEF_SAT_EN defined: clamp to the output range; undefined: keep the low bits (wrap).
module fir_coef_sequencer_mac_sat_unit
    import fir_coef_sequencer_pkg::*;
#(
    parameter int unsigned cant_bits = CANT_BITS_DEF,
    parameter int unsigned frac_bits = FRAC_BITS_DEF
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        clr_i,
    input  logic                        en_i,
    input  logic signed [cant_bits-1:0] coef_i,
    input  logic signed [cant_bits-1:0] tap_i,
    output logic        [cant_bits-1:0] result_o
);

    localparam int unsigned ProdBits = 2 * cant_bits;
    localparam int unsigned AccBits  = ProdBits + ACC_GUARD;

    logic signed [ProdBits-1:0] prod;
    logic signed [AccBits-1:0]  acc_q, acc_d;

`ifdef COEF_SAT_EN
    localparam logic signed [AccBits-1:0] SatMax =
        {{(AccBits - cant_bits + 1){1'b0}}, {(cant_bits - 1){1'b1}}};
    localparam logic signed [AccBits-1:0] SatMin = ~SatMax;
    logic signed [AccBits-1:0] acc_sh;
`endif

    always_comb begin
        prod  = ProdBits'(coef_i) * ProdBits'(tap_i);
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + AccBits'(prod);
        end
    end

    // Result reflects acc_d so the final sum is visible in the same cycle as the last step.
    always_comb begin
`ifdef COEF_SAT_EN
        acc_sh = acc_d >>> frac_bits;
        if (acc_sh > SatMax) begin
            result_o = SatMax[cant_bits-1:0];
        end else if (acc_sh < SatMin) begin
            result_o = SatMin[cant_bits-1:0];
        end else begin
            result_o = acc_sh[cant_bits-1:0];
        end
`else
        result_o = acc_d[frac_bits +: cant_bits];
`endif
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/fir_coef_sequencer.sv
// FIR sequencer: tap delay line, coefficient-table stepping and result handshake.
// Output saturation is enabled by defining COEF_SAT_EN; otherwise the result wraps.
module fir_coef_sequencer
    import fir_coef_sequencer_pkg::*;
#(
    parameter int unsigned cant_bits = CANT_BITS_DEF,
    parameter int unsigned frac_bits = FRAC_BITS_DEF,
    parameter int unsigned N_TAPS    = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [cant_bits-1:0] sample_in,
    input  logic                 sample_vld,
    output logic [3:0]           sel_cte,
    input  logic [cant_bits-1:0] cte,
    output logic [cant_bits-1:0] y_out,
    output logic                 y_vld,
    output logic                 busy,
    output logic                 overrun
);

    localparam logic [2:0] KLast = 3'(N_TAPS - 1);

    state_e               state_q, state_d;
    logic [2:0]           k_q, k_d;
    logic [cant_bits-1:0] taps_q [MAX_TAPS];
    logic [cant_bits-1:0] taps_d [MAX_TAPS];
    logic [cant_bits-1:0] y_out_q, y_out_d;
    logic                 y_vld_q, y_vld_d;
    logic                 busy_q, busy_d;
    logic [3:0]           sel_q, sel_d;
    logic                 accept;
    logic                 mac_en;
    logic [cant_bits-1:0] mac_result;

    assign accept = (state_q == IDLE) && sample_vld;
    assign mac_en = (state_q == MAC);

    fir_coef_sequencer_mac_sat_unit #(
        .cant_bits (cant_bits),
        .frac_bits (frac_bits)
    ) u_mac (
        .clk_i    (clk),
        .reset_i  (reset),
        .clr_i    (accept),
        .en_i     (mac_en),
        .coef_i   (cte),
        .tap_i    (taps_q[k_q]),
        .result_o (mac_result)
    );

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        taps_d  = taps_q;
        y_out_d = y_out_q;
        y_vld_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sample_vld) begin
                    // Slots at or beyond N_TAPS stay zero and are never selected.
                    taps_d[0] = sample_in;
                    for (int i = 1; i < int'(MAX_TAPS); i++) begin
                        taps_d[i] = (i < int'(N_TAPS)) ? taps_q[i-1] : '0;
                    end
                    k_d     = '0;
                    state_d = MAC;
                end
            end
            MAC: begin
                k_d = k_q + 3'd1;
                if (k_q == KLast) begin
                    k_d     = '0;
                    y_out_d = mac_result;
                    y_vld_d = 1'b1;
                    state_d = OUT;
                end
            end
            OUT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
        sel_d  = (state_d == MAC) ? {1'b0, k_d} : 4'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            taps_q  <= '{default: '0};
            y_out_q <= '0;
            y_vld_q <= 1'b0;
            busy_q  <= 1'b0;
            sel_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            taps_q  <= taps_d;
            y_out_q <= y_out_d;
            y_vld_q <= y_vld_d;
            busy_q  <= busy_d;
            sel_q   <= sel_d;
        end
    end

    assign sel_cte = sel_q;
    assign y_out   = y_out_q;
    assign y_vld   = y_vld_q;
    assign busy    = busy_q;
    assign overrun = sample_vld && busy_q;

endmodule

// File: tb/tb_fir_coef_sequencer.sv
// Self-checking bench for fir_coef_sequencer: directed scenarios plus random traffic
// against a transaction-level reference model (honours COEF_SAT_EN like the design).
module tb_fir_coef_sequencer;

    localparam int N = 3;

    logic        clk;
    logic        reset;
    logic [24:0] sample_in;
    logic        sample_vld;
    logic [3:0]  sel_cte;
    logic [24:0] cte;
    logic [24:0] y_out;
    logic        y_vld;
    logic        busy;
    logic        overrun;
    logic        force_tbl;

    int checks = 0;
    int errors = 0;

    // Reference model state: phase 0 = idle, 1..N = stepping taps, N+1 = result cycle.
    int          phase;
    longint      m_taps [N];
    logic [24:0] y_hold;
    logic [24:0] pending;
    logic        in_vld;
    logic        in_rst;
    logic [24:0] in_s;

    fir_coef_sequencer #(
        .cant_bits (25),
        .frac_bits (14),
        .N_TAPS    (N)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sample_in  (sample_in),
        .sample_vld (sample_vld),
        .sel_cte    (sel_cte),
        .cte        (cte),
        .y_out      (y_out),
        .y_vld      (y_vld),
        .busy       (busy),
        .overrun    (overrun)
    );

    function automatic logic [24:0] tbl(input logic [3:0] code, input logic frc);
        case (code)
            4'd0:    return frc ? 25'h0007FFF : 25'h0004000;
            4'd1:    return frc ? 25'h0007FFF : 25'h0007D71;
            4'd2:    return 25'h1FFC287;
            default: return 25'h0000000;
        endcase
    endfunction

    assign cte = tbl(sel_cte, force_tbl);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic longint sx25(input logic [24:0] v);
        return longint'($signed(v));
    endfunction

    function automatic logic [24:0] model_result();
        longint acc;
        longint sh;
        acc = 0;
        for (int k = 0; k < N; k++) begin
            acc += sx25(tbl(4'(k), force_tbl)) * m_taps[k];
        end
        sh = acc >>> 14;
`ifdef COEF_SAT_EN
        if (sh > 64'sd16777215) sh = 64'sd16777215;
        if (sh < -64'sd16777216) sh = -64'sd16777216;
`endif
        return sh[24:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        phase  = 0;
        y_hold = '0;
        for (int k = 0; k < N; k++) m_taps[k] = 0;
    endtask

    // Drive one cycle's inputs, then compare all outputs with the model.
    task automatic drive_check(input logic vld, input logic [24:0] s, input logic rst);
        logic       b_e;
        logic [3:0] sel_e;
        sample_vld = vld;
        sample_in  = s;
        reset      = rst;
        in_vld     = vld;
        in_s       = s;
        in_rst     = rst;
        #2;
        b_e   = (phase >= 1);
        sel_e = (phase >= 1 && phase <= N) ? 4'(phase - 1) : 4'd0;
        chk("busy", 32'(busy), 32'(b_e));
        chk("sel_cte", 32'(sel_cte), 32'(sel_e));
        chk("y_vld", 32'(y_vld), 32'(phase == N + 1));
        chk("y_out", 32'(y_out), 32'(y_hold));
        chk("overrun", 32'(overrun), 32'(vld && b_e));
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        if (in_rst) begin
            model_clear();
        end else if (phase == 0) begin
            if (in_vld) begin
                for (int k = N - 1; k > 0; k--) m_taps[k] = m_taps[k-1];
                m_taps[0] = sx25(in_s);
                pending   = model_result();
                phase     = 1;
            end
        end else begin
            phase++;
            if (phase == N + 1) y_hold = pending;
            else if (phase > N + 1) phase = 0;
        end
    endtask

    // One full transaction from idle plus an idle gap; optional constant check on the result.
    task automatic run_sample(input string tag, input logic [24:0] s, input logic do_const,
                              input logic [24:0] exp_y);
        logic [3:0] trace [N + 2];
        trace[0] = 4'd0;
        for (int k = 0; k < N; k++) trace[k+1] = 4'(k);
        trace[N+1] = 4'd0;
        for (int c = 0; c < N + 2; c++) begin
            drive_check(c == 0, s, 1'b0);
            chk({tag, "_sel"}, 32'(sel_cte), 32'(trace[c]));
            if (c == N + 1) begin
                chk({tag, "_vld"}, 32'(y_vld), 32'd1);
                if (do_const) chk({tag, "_y"}, 32'(y_out), 32'(exp_y));
            end
            advance();
        end
        drive_check(1'b0, '0, 1'b0);
        advance();
    endtask

    task automatic do_reset();
        drive_check(1'b0, '0, 1'b1);
        advance();
    endtask

    initial begin
        force_tbl  = 1'b0;
        reset      = 1'b1;
        sample_vld = 1'b0;
        sample_in  = '0;
        in_vld     = 1'b0;
        in_rst     = 1'b0;
        in_s       = '0;
        pending    = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;

        // Impulse response.
        run_sample("imp0", 25'h0004000, 1'b1, 25'h0004000);
        run_sample("imp1", 25'h0000000, 1'b1, 25'h0007D71);
        run_sample("imp2", 25'h0000000, 1'b1, 25'h1FFC287);

        // sample_vld held for six cycles from idle.
        for (int i = 0; i < 12; i++) begin
            drive_check(i < 6, 25'(i * 3 + 1), 1'b0);
            chk("ovr_pulse", 32'(overrun), 32'(i >= 1 && i <= 4));
            chk("ovr_yvld", 32'(y_vld), 32'(i == 4 || i == 9));
            advance();
        end

        // Reset during the second MAC cycle.
        drive_check(1'b1, 25'h0004000, 1'b0);
        advance();
        drive_check(1'b0, '0, 1'b0);
        advance();
        drive_check(1'b0, '0, 1'b1);
        advance();
        for (int i = 0; i < N + 2; i++) begin
            drive_check(1'b0, '0, 1'b0);
            chk("rst_novld", 32'(y_vld), 32'd0);
            advance();
        end
        run_sample("rimp0", 25'h0004000, 1'b1, 25'h0004000);
        run_sample("rimp1", 25'h0000000, 1'b1, 25'h0007D71);
        run_sample("rimp2", 25'h0000000, 1'b1, 25'h1FFC287);

        // Large positive result with boosted coefficients.
        do_reset();
        force_tbl = 1'b1;
        run_sample("sat0", 25'h0FFFFFF, 1'b0, '0);
        run_sample("sat1", 25'h0FFFFFF, 1'b0, '0);
`ifdef COEF_SAT_EN
        run_sample("sat2", 25'h0FFFFFF, 1'b1, 25'h0FFFFFF);
`else
        run_sample("sat2", 25'h0FFFFFF, 1'b0, '0);
`endif
        force_tbl = 1'b0;

        // -1 LSB times +1.0 must stay -1 LSB.
        do_reset();
        run_sample("neg", 25'h1FFFFFF, 1'b1, 25'h1FFFFFF);

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            logic        r_rst;
            logic        r_vld;
            logic [24:0] r_s;
            r_rst = ($urandom_range(0, 49) == 0);
            r_vld = ($urandom_range(0, 2) != 0);
            r_s   = ($urandom_range(0, 3) == 0) ? 25'($urandom_range(0, 255)) : 25'($urandom);
            drive_check(r_vld, r_s, r_rst);
            advance();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
